// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions used by the register file, decoder and ALU control.
// Holds the data width, register-address type and the hardwired zero-register index.
package cpu_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = 5'd0;

   // Some register files are configured smaller than the 5-bit address space allows.
   function automatic logic addr_in_range(input reg_addr_t addr, input int nregs);
      return (int'(addr) < nregs);
   endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port: zero-register and out-of-range masking plus the optional
// write-first bypass from the write-back bus.
module reg_read_port
   import cpu_pkg::reg_addr_t, cpu_pkg::ZERO_REG, cpu_pkg::addr_in_range;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic [XLEN-1:0] regs_i [NREGS],
   input  reg_addr_t       rd_addr_i,
   input  logic            wr_valid_i,
   input  reg_addr_t       wr_addr_i,
   input  logic [XLEN-1:0] wr_data_i,
   output logic [XLEN-1:0] rd_data_o
);

   logic bypass_hit;

   // wr_valid_i is already qualified with reset, enable, non-zero and in-range address.
   assign bypass_hit = BYPASS && wr_valid_i && (rd_addr_i == wr_addr_i);

   always_comb begin
      rd_data_o = '0;
      if (bypass_hit) begin
         rd_data_o = wr_data_i;
      end else if (rd_addr_i != ZERO_REG && addr_in_range(rd_addr_i, NREGS)) begin
         rd_data_o = regs_i[rd_addr_i];
      end
   end

endmodule

// File: rtl/register_file.sv
// General-purpose register file feeding the ALU: two bypassable read ports, one write-back
// port, a non-bypassed debug read port, and entry 0 hardwired to zero.
module register_file
   import cpu_pkg::reg_addr_t, cpu_pkg::ZERO_REG, cpu_pkg::addr_in_range;
#(
   parameter int XLEN   = cpu_pkg::XLEN,
   parameter int NREGS  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  reg_addr_t       read_reg1,
   input  reg_addr_t       read_reg2,
   input  reg_addr_t       write_reg,
   input  logic [XLEN-1:0] write_data,
   input  logic            reg_write,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   input  reg_addr_t       dbg_reg,
   output logic [XLEN-1:0] dbg_data
);

   logic [XLEN-1:0] regs_q  [1:NREGS-1];
   logic [XLEN-1:0] regs_d  [1:NREGS-1];
   logic [XLEN-1:0] rd_view [NREGS];
   logic            wr_valid;
   reg_addr_t       rd_addr [2];
   logic [XLEN-1:0] rd_data [2];

   // Reset wins over a write on the same edge, so a write is only valid outside reset.
   assign wr_valid = !rst && reg_write && (write_reg != ZERO_REG)
                     && addr_in_range(write_reg, NREGS);

   always_comb begin
      for (int i = 1; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_valid && (int'(write_reg) == i)) begin
            regs_d[i] = write_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NREGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   always_comb begin
      rd_view[0] = '0;
      for (int i = 1; i < NREGS; i++) begin
         rd_view[i] = regs_q[i];
      end
   end

   assign rd_addr[0] = read_reg1;
   assign rd_addr[1] = read_reg2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd_port
         reg_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .BYPASS (BYPASS)
         ) u_port (
            .regs_i     (rd_view),
            .rd_addr_i  (rd_addr[gi]),
            .wr_valid_i (wr_valid),
            .wr_addr_i  (write_reg),
            .wr_data_i  (write_data),
            .rd_data_o  (rd_data[gi])
         );
      end
   endgenerate

   assign read_data1 = rd_data[0];
   assign read_data2 = rd_data[1];

   // Debug reads always show stored contents, never the in-flight write.
   assign dbg_data = addr_in_range(dbg_reg, NREGS) ? rd_view[dbg_reg] : '0;

endmodule
